// File: rtl/dmi_pkg.sv
// Shared types and constants for the DMI initiator.
// Ports: none (package).
package dmi_pkg;

    localparam int DMI_ADDR_W = 7;
    localparam int DMI_DATA_W = 32;

    typedef enum logic [1:0] {
        NOP   = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RSVD  = 2'b11
    } dmi_op_e;

    typedef enum logic [1:0] {
        SUCCESS = 2'b00,
        FAILED  = 2'b10,
        BUSY    = 2'b11
    } dmi_status_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        RESP
    } dmi_init_state_e;

    // The reserved status code 01 is reported to the host as a failure.
    function automatic dmi_status_e to_status(input logic [1:0] raw);
        case (raw)
            2'b00:   return SUCCESS;
            2'b11:   return BUSY;
            default: return FAILED;
        endcase
    endfunction

endpackage

// File: rtl/dmi_timeout_ctr.sv
// Response timeout counter: cleared by clr_i, counts while en_i.
// Ports: clk, reset, clr_i, en_i, expire_o (high while count is TIMEOUT_CYCLES-1).
module dmi_timeout_ctr
    import dmi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expire_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmi_initiator.sv
// DMI master: takes host requests, issues them on the DMI request channel,
// returns the DMI response (or a timeout failure) to the host.
// Ports: host_req_* (host request), host_rsp_* (host response),
//        dmi_req_* / dmi_rsp_* (debug module side), timeout_o (abort pulse).
// Optional: define DMI_BUSY_RETRY_EN to re-issue requests answered busy.
module dmi_initiator
    import dmi_pkg::*;
#(
    parameter int ADDR_W         = DMI_ADDR_W,
    parameter int DATA_W         = DMI_DATA_W,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int MAX_RETRIES    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_req_valid_i,
    output logic              host_req_ready_o,
    input  logic [1:0]        host_req_op_i,
    input  logic [ADDR_W-1:0] host_req_addr_i,
    input  logic [DATA_W-1:0] host_req_data_i,
    output logic              host_rsp_valid_o,
    input  logic              host_rsp_ready_i,
    output logic [1:0]        host_rsp_op_o,
    output logic [DATA_W-1:0] host_rsp_data_o,
    output logic              dmi_req_valid_o,
    input  logic              dmi_req_ready_i,
    output logic [1:0]        dmi_req_op_o,
    output logic [ADDR_W-1:0] dmi_req_address_o,
    output logic [DATA_W-1:0] dmi_req_data_o,
    input  logic              dmi_rsp_valid_i,
    input  logic [1:0]        dmi_rsp_op_i,
    input  logic [DATA_W-1:0] dmi_rsp_data_i,
    output logic              timeout_o
);

    dmi_init_state_e   state_q;
    dmi_op_e           req_op_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_data_q;
    logic              req_valid_q;
    logic              host_ready_q;
    logic              rsp_valid_q;
    dmi_status_e       rsp_op_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              timeout_q;

    logic              in_flight;
    logic              handshake;
    logic              rsp_cap;
    dmi_status_e       rsp_status;
    logic [DATA_W-1:0] rsp_data_sel;
    logic              retry_now;
    logic              tmr_expire;

    assign in_flight  = (state_q == REQ) || (state_q == WAIT_RSP);
    assign handshake  = (state_q == REQ) && dmi_req_ready_i;
    // A response is only taken after (or with) the request handshake.
    assign rsp_cap    = dmi_rsp_valid_i && (handshake || state_q == WAIT_RSP);
    assign rsp_status = to_status(dmi_rsp_op_i);
    assign rsp_data_sel = (req_op_q == READ && rsp_status == SUCCESS)
                        ? dmi_rsp_data_i : '0;

`ifdef DMI_BUSY_RETRY_EN
    localparam int RW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;
    logic [RW-1:0] retry_q;
    assign retry_now = rsp_cap && (rsp_status == BUSY)
                    && (int'(retry_q) < MAX_RETRIES);
`else
    // Busy is always handed to the host; the retry limit has no effect.
    assign retry_now = 1'b0 && (MAX_RETRIES != 0);
`endif

    dmi_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmr (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (!in_flight || retry_now),
        .en_i     (in_flight),
        .expire_o (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            req_op_q     <= NOP;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_valid_q  <= 1'b0;
            host_ready_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_op_q     <= SUCCESS;
            rsp_data_q   <= '0;
            timeout_q    <= 1'b0;
`ifdef DMI_BUSY_RETRY_EN
            retry_q      <= '0;
`endif
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
`ifdef DMI_BUSY_RETRY_EN
                    retry_q <= '0;
`endif
                    if (host_req_valid_i && host_ready_q) begin
                        host_ready_q <= 1'b0;
                        req_op_q     <= dmi_op_e'(host_req_op_i);
                        req_addr_q   <= host_req_addr_i;
                        req_data_q   <= host_req_data_i;
                        case (dmi_op_e'(host_req_op_i))
                            READ, WRITE: begin
                                state_q     <= REQ;
                                req_valid_q <= 1'b1;
                            end
                            NOP: begin
                                state_q     <= RESP;
                                rsp_valid_q <= 1'b1;
                                rsp_op_q    <= SUCCESS;
                                rsp_data_q  <= '0;
                            end
                            default: begin
                                state_q     <= RESP;
                                rsp_valid_q <= 1'b1;
                                rsp_op_q    <= FAILED;
                                rsp_data_q  <= '0;
                            end
                        endcase
                    end
                end
                REQ, WAIT_RSP: begin
                    if (handshake) begin
                        state_q     <= WAIT_RSP;
                        req_valid_q <= 1'b0;
                    end
                    // A response in the expiry cycle beats the timeout.
                    if (rsp_cap) begin
                        if (retry_now) begin
                            state_q     <= REQ;
                            req_valid_q <= 1'b1;
`ifdef DMI_BUSY_RETRY_EN
                            retry_q     <= retry_q + 1'b1;
`endif
                        end else begin
                            state_q     <= RESP;
                            req_valid_q <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_op_q    <= rsp_status;
                            rsp_data_q  <= rsp_data_sel;
                        end
                    end else if (tmr_expire) begin
                        state_q     <= RESP;
                        timeout_q   <= 1'b1;
                        req_valid_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_op_q    <= FAILED;
                        rsp_data_q  <= '0;
                    end
                end
                RESP: begin
                    if (host_rsp_ready_i) begin
                        state_q      <= IDLE;
                        rsp_valid_q  <= 1'b0;
                        host_ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign host_req_ready_o  = host_ready_q;
    assign host_rsp_valid_o  = rsp_valid_q;
    assign host_rsp_op_o     = rsp_op_q;
    assign host_rsp_data_o   = rsp_data_q;
    assign dmi_req_valid_o   = req_valid_q;
    assign dmi_req_op_o      = req_op_q;
    assign dmi_req_address_o = req_addr_q;
    assign dmi_req_data_o    = req_data_q;
    assign timeout_o         = timeout_q;

endmodule
